core_pll_supervisor: RTL and testbench

//  Sequences the core PLL: drives its rst, qualifies its async locked output, and releases
//  per-clock-domain resets in order (53.6 MHz, then three 6.7 MHz phases).

---
 rtl/pll_supv_pkg.sv | 13 +
 rtl/core_pll_supervisor_sync_2ff.sv | 23 ++
 rtl/core_pll_supervisor.sv | 190 +++++++++++++++++++
 tb/tb_core_pll_supervisor.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_supv_pkg.sv
// rtl/pll_supv_pkg.sv - shared state type, widths and saturating helper for the core PLL supervisor
package pll_supv_pkg;

   typedef enum logic [2:0] {HOLD, WAIT, FILTER, REL, RUN, FAIL} supv_state_t;

   localparam int TMR_W  = 20;
   localparam int STAT_W = 8;

   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      return (&v) ? v : v + STAT_W'(1);
   endfunction

endpackage

// File: rtl/core_pll_supervisor_sync_2ff.sv
// rtl/core_pll_supervisor_sync_2ff.sv - two-flop synchroniser, async active-low reset to 0
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/core_pll_supervisor.sv
// rtl/core_pll_supervisor.sv - core PLL reset/lock sequencer with ordered domain reset release
// Optional status counters (retry_count, lock_loss_count) when PLL_SUPV_STATUS_EN is defined.
module core_pll_supervisor
   import pll_supv_pkg::*;
#(
   parameter int N_DOMAINS    = 4,
   parameter int RST_HOLD     = 16,
   parameter int LOCK_TIMEOUT = 65536,
   parameter int LOCK_FILTER  = 256,
   parameter int DOMAIN_GAP   = 8,
   parameter int MAX_RETRIES  = 3
) (
   input  logic                 clk_74a,
   input  logic                 reset_n,
   input  logic                 pll_locked,
   input  logic                 reconfig_req,
   output logic                 pll_rst,
   output logic [N_DOMAINS-1:0] domain_reset_n,
   output logic                 all_ready,
   output logic                 reconfig_ack,
   output logic                 fail
`ifdef PLL_SUPV_STATUS_EN
   ,
   output logic [STAT_W-1:0]    retry_count,
   output logic [STAT_W-1:0]    lock_loss_count
`endif
);

   logic                 locked_s;
   logic                 req_q;
   logic                 req_rise;
   supv_state_t          state, state_nx;
   logic [TMR_W-1:0]     tmr, tmr_nx;
   logic [STAT_W-1:0]    retry_cnt, retry_nx;
   logic                 ack_pend, pend_nx;
   logic                 pll_rst_nx, ready_nx, ack_nx, fail_nx;
   logic [N_DOMAINS-1:0] dom_nx;
   logic                 timeout, lost, abort, go_hold, run_entry;

   sync_2ff #(.WIDTH(1)) u_lock_sync (
      .clk   (clk_74a),
      .rst_n (reset_n),
      .d     (pll_locked),
      .q     (locked_s)
   );

   assign req_rise = reconfig_req & ~req_q;

   always_comb begin
      state_nx  = state;
      tmr_nx    = tmr;
      retry_nx  = retry_cnt;
      pend_nx   = ack_pend;
      dom_nx    = domain_reset_n;
      timeout   = 1'b0;
      lost      = 1'b0;
      go_hold   = 1'b0;
      run_entry = 1'b0;
      abort     = req_rise && (state != FAIL);

      // tmr counts elapsed cycles in the current state and restarts at 0 on every entry
      case (state)
         HOLD: begin
            if (tmr == TMR_W'(RST_HOLD - 1)) begin
               state_nx = WAIT;
               tmr_nx   = '0;
            end else begin
               tmr_nx = tmr + TMR_W'(1);
            end
         end
         WAIT: begin
            if (locked_s) begin
               state_nx = FILTER;
               tmr_nx   = '0;
            end else if (tmr == TMR_W'(LOCK_TIMEOUT - 1)) begin
               timeout = 1'b1;
            end else begin
               tmr_nx = tmr + TMR_W'(1);
            end
         end
         FILTER: begin
            if (!locked_s) begin
               state_nx = WAIT;
               tmr_nx   = '0;
            end else if (tmr == TMR_W'(LOCK_FILTER - 1)) begin
               state_nx = REL;
               tmr_nx   = '0;
               dom_nx   = N_DOMAINS'(1);
            end else begin
               tmr_nx = tmr + TMR_W'(1);
            end
         end
         REL: begin
            if (!locked_s) begin
               lost = 1'b1;
            end else if (tmr == TMR_W'(DOMAIN_GAP - 1)) begin
               tmr_nx = '0;
               dom_nx = (domain_reset_n << 1) | N_DOMAINS'(1);
            end else begin
               tmr_nx = tmr + TMR_W'(1);
            end
         end
         RUN: begin
            if (!locked_s) lost = 1'b1;
         end
         FAIL: begin
            if (req_rise) begin
               go_hold  = 1'b1;
               retry_nx = '0;
            end
         end
         default: go_hold = 1'b1;
      endcase

      if (state_nx == REL && (&dom_nx)) state_nx = RUN;

      if (timeout) begin
         retry_nx = sat_inc(retry_cnt);
         if (retry_nx >= STAT_W'(MAX_RETRIES)) state_nx = FAIL;
         else go_hold = 1'b1;
      end

      // a reconfig edge overrides every other event in the same cycle
      if (lost || abort) go_hold = 1'b1;
      if (abort) pend_nx = 1'b1;

      if (go_hold) begin
         state_nx = HOLD;
         tmr_nx   = '0;
      end

      if (state_nx == RUN && state != RUN) begin
         run_entry = 1'b1;
         retry_nx  = '0;
         pend_nx   = 1'b0;
      end

      if (!(state_nx inside {REL, RUN})) dom_nx = '0;
      pll_rst_nx = (state_nx == HOLD) || (state_nx == FAIL);
      ready_nx   = (state_nx == RUN);
      fail_nx    = (state_nx == FAIL);
      ack_nx     = run_entry && ack_pend;
   end

   always_ff @(posedge clk_74a or negedge reset_n) begin
      if (!reset_n) begin
         state          <= HOLD;
         tmr            <= '0;
         retry_cnt      <= '0;
         req_q          <= 1'b0;
         ack_pend       <= 1'b0;
         pll_rst        <= 1'b1;
         domain_reset_n <= '0;
         all_ready      <= 1'b0;
         reconfig_ack   <= 1'b0;
         fail           <= 1'b0;
      end else begin
         state          <= state_nx;
         tmr            <= tmr_nx;
         retry_cnt      <= retry_nx;
         req_q          <= reconfig_req;
         ack_pend       <= pend_nx;
         pll_rst        <= pll_rst_nx;
         domain_reset_n <= dom_nx;
         all_ready      <= ready_nx;
         reconfig_ack   <= ack_nx;
         fail           <= fail_nx;
      end
   end

`ifdef PLL_SUPV_STATUS_EN
   logic [STAT_W-1:0] rstat, lstat;

   // a lock loss coinciding with a reconfig edge is handled as reconfig only
   always_ff @(posedge clk_74a or negedge reset_n) begin
      if (!reset_n) begin
         rstat <= '0;
         lstat <= '0;
      end else begin
         if (run_entry) rstat <= '0;
         else if (timeout) rstat <= sat_inc(rstat);
         if (lost && !abort) lstat <= sat_inc(lstat);
      end
   end

   assign retry_count     = rstat;
   assign lock_loss_count = lstat;
`endif

endmodule

// File: tb/tb_core_pll_supervisor.sv
// tb/tb_core_pll_supervisor.sv - directed vector bench for core_pll_supervisor
// Status-counter checks are compiled in when PLL_SUPV_STATUS_EN is defined.
`timescale 1ns/1ps
module tb_core_pll_supervisor;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rstn_v [2];
   logic       lock_v [2];
   logic       req_v  [2];
   logic       pll_rst_v [2];
   logic [3:0] dom_v [2];
   logic       ready_v [2];
   logic       ack_v [2];
   logic       fail_v [2];
`ifdef PLL_SUPV_STATUS_EN
   logic [7:0] rc_v [2];
   logic [7:0] ll_v [2];
`endif

   core_pll_supervisor #(.LOCK_TIMEOUT(1024)) dut (
      .clk_74a        (clk),
      .reset_n        (rstn_v[0]),
      .pll_locked     (lock_v[0]),
      .reconfig_req   (req_v[0]),
      .pll_rst        (pll_rst_v[0]),
      .domain_reset_n (dom_v[0]),
      .all_ready      (ready_v[0]),
      .reconfig_ack   (ack_v[0]),
      .fail           (fail_v[0])
`ifdef PLL_SUPV_STATUS_EN
      ,
      .retry_count    (rc_v[0]),
      .lock_loss_count(ll_v[0])
`endif
   );

   core_pll_supervisor #(.LOCK_TIMEOUT(64)) dut_to (
      .clk_74a        (clk),
      .reset_n        (rstn_v[1]),
      .pll_locked     (lock_v[1]),
      .reconfig_req   (req_v[1]),
      .pll_rst        (pll_rst_v[1]),
      .domain_reset_n (dom_v[1]),
      .all_ready      (ready_v[1]),
      .reconfig_ack   (ack_v[1]),
      .fail           (fail_v[1])
`ifdef PLL_SUPV_STATUS_EN
      ,
      .retry_count    (rc_v[1]),
      .lock_loss_count(ll_v[1])
`endif
   );

   typedef struct {
      int         at;
      logic       lock;
      logic       req;
      logic [7:0] exp;
   } vec_t;

   int n_total  = 0;
   int n_passed = 0;
   int cyc      = 0;

   function automatic vec_t mk(input int at, input logic lock, input logic req, input logic rst,
                               input logic [3:0] dom, input logic rdy, input logic ack, input logic fl);
      vec_t v;
      v.at  = at;
      v.lock = lock;
      v.req = req;
      v.exp = {rst, dom, rdy, ack, fl};
      return v;
   endfunction

   function automatic logic [7:0] outs(input int u);
      return {pll_rst_v[u], dom_v[u], ready_v[u], ack_v[u], fail_v[u]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else n_passed++;
   endtask

   task automatic goto(input int n);
      while (cyc < n) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic release_dut(input int u);
      @(negedge clk);
      rstn_v[u] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rstn_v[u] = 1'b1;
      cyc = 0;
   endtask

   // each row: check outputs at cycle 'at', then drive the row's inputs
   task automatic run(input int u, input string tag, input vec_t v[$]);
      for (int i = 0; i < v.size(); i++) begin
         goto(v[i].at);
         check($sformatf("%s@%0d", tag, v[i].at), outs(u), v[i].exp);
         lock_v[u] = v[i].lock;
         req_v[u]  = v[i].req;
      end
   endtask

   vec_t t_run[$];
   vec_t t_glitch[$];
   vec_t t_sim[$];
   vec_t t_to[$];

   initial begin
      rstn_v = '{1'b0, 1'b0};
      lock_v = '{1'b0, 1'b0};
      req_v  = '{1'b0, 1'b0};

      // lock at 100, full release, then a one-cycle lock drop in RUN at 400
      t_run.push_back(mk(  0, 0, 0, 1, 4'b0000, 0, 0, 0));
      t_run.push_back(mk( 15, 0, 0, 1, 4'b0000, 0, 0, 0));
      t_run.push_back(mk( 16, 0, 0, 0, 4'b0000, 0, 0, 0));
      t_run.push_back(mk(100, 1, 0, 0, 4'b0000, 0, 0, 0));
      t_run.push_back(mk(358, 1, 0, 0, 4'b0000, 0, 0, 0));
      t_run.push_back(mk(359, 1, 0, 0, 4'b0001, 0, 0, 0));
      t_run.push_back(mk(366, 1, 0, 0, 4'b0001, 0, 0, 0));
      t_run.push_back(mk(367, 1, 0, 0, 4'b0011, 0, 0, 0));
      t_run.push_back(mk(375, 1, 0, 0, 4'b0111, 0, 0, 0));
      t_run.push_back(mk(382, 1, 0, 0, 4'b0111, 0, 0, 0));
      t_run.push_back(mk(383, 1, 0, 0, 4'b1111, 1, 0, 0));
      t_run.push_back(mk(400, 0, 0, 0, 4'b1111, 1, 0, 0));
      t_run.push_back(mk(401, 1, 0, 0, 4'b1111, 1, 0, 0));
      t_run.push_back(mk(402, 1, 0, 0, 4'b1111, 1, 0, 0));
      t_run.push_back(mk(403, 1, 0, 1, 4'b0000, 0, 0, 0));
      t_run.push_back(mk(418, 1, 0, 1, 4'b0000, 0, 0, 0));
      t_run.push_back(mk(419, 1, 0, 0, 4'b0000, 0, 0, 0));
      t_run.push_back(mk(675, 1, 0, 0, 4'b0000, 0, 0, 0));
      t_run.push_back(mk(676, 1, 0, 0, 4'b0001, 0, 0, 0));
      t_run.push_back(mk(699, 1, 0, 0, 4'b0111, 0, 0, 0));
      t_run.push_back(mk(700, 1, 0, 0, 4'b1111, 1, 0, 0));

      // filter glitch at count 200, then reconfig in REL and a second edge in HOLD
      t_glitch.push_back(mk(  0, 1, 0, 1, 4'b0000, 0, 0, 0));
      t_glitch.push_back(mk( 16, 1, 0, 0, 4'b0000, 0, 0, 0));
      t_glitch.push_back(mk(215, 0, 0, 0, 4'b0000, 0, 0, 0));
      t_glitch.push_back(mk(216, 1, 0, 0, 4'b0000, 0, 0, 0));
      t_glitch.push_back(mk(273, 1, 0, 0, 4'b0000, 0, 0, 0));
      t_glitch.push_back(mk(474, 1, 0, 0, 4'b0000, 0, 0, 0));
      t_glitch.push_back(mk(475, 1, 0, 0, 4'b0001, 0, 0, 0));
      t_glitch.push_back(mk(483, 1, 0, 0, 4'b0011, 0, 0, 0));
      t_glitch.push_back(mk(485, 1, 1, 0, 4'b0011, 0, 0, 0));
      t_glitch.push_back(mk(486, 1, 1, 1, 4'b0000, 0, 0, 0));
      t_glitch.push_back(mk(490, 1, 0, 1, 4'b0000, 0, 0, 0));
      t_glitch.push_back(mk(495, 1, 1, 1, 4'b0000, 0, 0, 0));
      t_glitch.push_back(mk(502, 1, 1, 1, 4'b0000, 0, 0, 0));
      t_glitch.push_back(mk(511, 1, 1, 1, 4'b0000, 0, 0, 0));
      t_glitch.push_back(mk(512, 1, 1, 0, 4'b0000, 0, 0, 0));
      t_glitch.push_back(mk(768, 1, 1, 0, 4'b0000, 0, 0, 0));
      t_glitch.push_back(mk(769, 1, 1, 0, 4'b0001, 0, 0, 0));
      t_glitch.push_back(mk(792, 1, 1, 0, 4'b0111, 0, 0, 0));
      t_glitch.push_back(mk(793, 1, 1, 0, 4'b1111, 1, 1, 0));
      t_glitch.push_back(mk(794, 1, 1, 0, 4'b1111, 1, 0, 0));
      t_glitch.push_back(mk(800, 1, 0, 0, 4'b1111, 1, 0, 0));

      // lock loss and reconfig edge seen on the same edge in REL
      t_sim.push_back(mk(  0, 1, 0, 1, 4'b0000, 0, 0, 0));
      t_sim.push_back(mk(280, 0, 0, 0, 4'b0001, 0, 0, 0));
      t_sim.push_back(mk(281, 1, 0, 0, 4'b0011, 0, 0, 0));
      t_sim.push_back(mk(282, 1, 1, 0, 4'b0011, 0, 0, 0));
      t_sim.push_back(mk(283, 1, 1, 1, 4'b0000, 0, 0, 0));
      t_sim.push_back(mk(298, 1, 1, 1, 4'b0000, 0, 0, 0));
      t_sim.push_back(mk(299, 1, 1, 0, 4'b0000, 0, 0, 0));
      t_sim.push_back(mk(555, 1, 1, 0, 4'b0000, 0, 0, 0));
      t_sim.push_back(mk(556, 1, 1, 0, 4'b0001, 0, 0, 0));
      t_sim.push_back(mk(579, 1, 1, 0, 4'b0111, 0, 0, 0));
      t_sim.push_back(mk(580, 1, 1, 0, 4'b1111, 1, 1, 0));
      t_sim.push_back(mk(581, 1, 0, 0, 4'b1111, 1, 0, 0));

      // no lock, LOCK_TIMEOUT=64: three attempts then sticky fail, reconfig clears it
      t_to.push_back(mk(  0, 0, 0, 1, 4'b0000, 0, 0, 0));
      t_to.push_back(mk( 15, 0, 0, 1, 4'b0000, 0, 0, 0));
      t_to.push_back(mk( 16, 0, 0, 0, 4'b0000, 0, 0, 0));
      t_to.push_back(mk( 79, 0, 0, 0, 4'b0000, 0, 0, 0));
      t_to.push_back(mk( 80, 0, 0, 1, 4'b0000, 0, 0, 0));
      t_to.push_back(mk( 95, 0, 0, 1, 4'b0000, 0, 0, 0));
      t_to.push_back(mk( 96, 0, 0, 0, 4'b0000, 0, 0, 0));
      t_to.push_back(mk(160, 0, 0, 1, 4'b0000, 0, 0, 0));
      t_to.push_back(mk(176, 0, 0, 0, 4'b0000, 0, 0, 0));
      t_to.push_back(mk(239, 0, 0, 0, 4'b0000, 0, 0, 0));
      t_to.push_back(mk(240, 0, 0, 1, 4'b0000, 0, 0, 1));
      t_to.push_back(mk(400, 0, 1, 1, 4'b0000, 0, 0, 1));
      t_to.push_back(mk(401, 0, 1, 1, 4'b0000, 0, 0, 0));
      t_to.push_back(mk(416, 0, 1, 1, 4'b0000, 0, 0, 0));
      t_to.push_back(mk(417, 0, 1, 0, 4'b0000, 0, 0, 0));

      release_dut(0);
      run(0, "run", t_run);
`ifdef PLL_SUPV_STATUS_EN
      check("loss_count_run", ll_v[0], 1);
`endif

      release_dut(0);
      run(0, "glitch", t_glitch);
`ifdef PLL_SUPV_STATUS_EN
      check("retry_count_glitch", rc_v[0], 0);
      check("loss_count_after_reset", ll_v[0], 0);
`endif

      release_dut(0);
      run(0, "sim", t_sim);
      req_v[0] = 1'b0;
`ifdef PLL_SUPV_STATUS_EN
      check("loss_count_sim", ll_v[0], 0);
`endif

      // asynchronous reset mid-REL
      release_dut(0);
      goto(285);
      check("rel_before_rst", outs(0), 8'b0_0011_000);
      #2 rstn_v[0] = 1'b0;
      #1 check("async_rst", outs(0), 8'b1_0000_000);
      @(negedge clk);
      check("rst_held", outs(0), 8'b1_0000_000);
      rstn_v[0] = 1'b1;

      release_dut(1);
      run(1, "timeout", t_to);
`ifdef PLL_SUPV_STATUS_EN
      check("retry_count_fail", rc_v[1], 3);
`endif

      $display("%0d/%0d checks passed", n_passed, n_total);
      $finish;
   end

endmodule
